control_puente_rtc: RTL and testbench

//  Parametrised bridge between the processor port bus (cs/writestrobe/readstrobe, dir, dato) and the RTC bus engine.

---
 rtl/rtc_puente_pkg.sv | 38 +++
 rtl/decodificador_dir.sv | 59 +++++
 rtl/control_puente_rtc.sv | 195 +++++++++++++++++++
 tb/tb_control_puente_rtc.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rtc_puente_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_puente_pkg
//  Description : Shared state encoding and constants for the processor-to-RTC
//                bus bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package rtc_puente_pkg;

   // 3-bit state codes of the bridge controller
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_BUS_WR = 3'd2;
   localparam logic [2:0] ST_BUS_RD = 3'd3;
   localparam logic [2:0] ST_LOCAL  = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;
   localparam logic [2:0] ST_ERR    = 3'd6;
   localparam logic [2:0] ST_HOLD   = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_DECODE = ST_DECODE,
      S_BUS_WR = ST_BUS_WR,
      S_BUS_RD = ST_BUS_RD,
      S_LOCAL  = ST_LOCAL,
      S_DONE   = ST_DONE,
      S_ERR    = ST_ERR,
      S_HOLD   = ST_HOLD
   } estado_t;

   // Read value returned on any failed transaction (sliced to the data width)
   localparam logic [63:0] ERR_CODE = '1;

   // Memory index reported for IDs that do not map to an engine register
   localparam int DIRMEM_NONE = 0;

endpackage
`default_nettype wire

// File: rtl/decodificador_dir.sv
`default_nettype none
// ============================================================================
//  Module      : decodificador_dir
//  Description : Combinational port-ID decoder. Maps time, date and local
//                register windows onto consecutive memory indices starting
//                at 1; index 0 means "not mapped".
//  Revision    : 1.0 - initial release
// ============================================================================
module decodificador_dir
   import rtc_puente_pkg::*;
#(
   parameter int            AW      = 8,
   parameter int            MAW     = 4,
   parameter logic [AW-1:0] ADDR_T0 = 8'h21,
   parameter int            N_T     = 6,
   parameter logic [AW-1:0] ADDR_F0 = 8'h41,
   parameter int            N_F     = 3,
   parameter logic [AW-1:0] ADDR_L0 = 8'h0A,
   parameter int            N_L     = 2
) (
   input  logic [AW-1:0]  dir_i,
   output logic [MAW-1:0] dirmem_o,
   output logic           es_local_o,
   output logic           valido_o
);

   localparam int BASE_T = 1;
   localparam int BASE_F = N_T + 1;
   localparam int BASE_L = N_T + N_F + 1;

   logic [AW-1:0] w_off_t;
   logic [AW-1:0] w_off_f;
   logic [AW-1:0] w_off_l;

   // Offsets wrap in AW bits, so an ID below the window base lands far out of range
   assign w_off_t = dir_i - ADDR_T0;
   assign w_off_f = dir_i - ADDR_F0;
   assign w_off_l = dir_i - ADDR_L0;

   // Window match in fixed priority order: time, date, local
   always_comb begin
      dirmem_o   = MAW'(DIRMEM_NONE);
      es_local_o = 1'b0;
      valido_o   = 1'b0;
      if (w_off_t < AW'(N_T)) begin
         dirmem_o = MAW'(BASE_T + int'(w_off_t));
         valido_o = 1'b1;
      end else if (w_off_f < AW'(N_F)) begin
         dirmem_o = MAW'(BASE_F + int'(w_off_f));
         valido_o = 1'b1;
      end else if (w_off_l < AW'(N_L)) begin
         dirmem_o   = MAW'(BASE_L + int'(w_off_l));
         es_local_o = 1'b1;
         valido_o   = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/control_puente_rtc.sv
`default_nettype none
// ============================================================================
//  Module      : control_puente_rtc
//  Description : Bridge from the processor port bus to the RTC bus engine.
//                Accepts one transaction per chip-select assertion, issues a
//                single-cycle engine request, waits for the acknowledge with
//                a timeout and reports data, done strobe and error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_puente_rtc
   import rtc_puente_pkg::*;
#(
   parameter int            DW      = 8,
   parameter int            AW      = 8,
   parameter int            MAW     = 4,
   parameter logic [AW-1:0] ADDR_T0 = 8'h21,
   parameter int            N_T     = 6,
   parameter logic [AW-1:0] ADDR_F0 = 8'h41,
   parameter int            N_F     = 3,
   parameter logic [AW-1:0] ADDR_L0 = 8'h0A,
   parameter int            N_L     = 2,
   parameter int            TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           cs,
   input  logic           writestrobe,
   input  logic           readstrobe,
   input  logic [AW-1:0]  dir,
   input  logic [DW-1:0]  dato,
   input  logic [DW-1:0]  datomem,
   input  logic           esclisto,
   input  logic           memorialisto,
   output logic           actesc,
   output logic           actlec,
   output logic [MAW-1:0] dirmem,
   output logic [DW-1:0]  datoreg,
   output logic [DW-1:0]  datoout,
   output logic           listo,
   output logic           error,
   output logic           ocupado
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [MAW-1:0] w_dirmem;
   logic           w_es_local;
   logic           w_valido;

   estado_t        state_q;
   logic           lectura_q;
   logic           local_q;
   logic           valido_q;
   logic [TW-1:0]  cnt_q;
   logic           actesc_q;
   logic           actlec_q;
   logic [MAW-1:0] dirmem_q;
   logic [DW-1:0]  datoreg_q;
   logic [DW-1:0]  datoout_q;
   logic           listo_q;
   logic           error_q;
   logic           ocupado_q;

   decodificador_dir #(
      .AW      (AW),
      .MAW     (MAW),
      .ADDR_T0 (ADDR_T0),
      .N_T     (N_T),
      .ADDR_F0 (ADDR_F0),
      .N_F     (N_F),
      .ADDR_L0 (ADDR_L0),
      .N_L     (N_L)
   ) u_decodificador (
      .dir_i      (dir),
      .dirmem_o   (w_dirmem),
      .es_local_o (w_es_local),
      .valido_o   (w_valido)
   );

   // Controller FSM; all outputs registered, listo/actesc/actlec self-clear
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         lectura_q <= 1'b0;
         local_q   <= 1'b0;
         valido_q  <= 1'b0;
         cnt_q     <= '0;
         actesc_q  <= 1'b0;
         actlec_q  <= 1'b0;
         dirmem_q  <= '0;
         datoreg_q <= '0;
         datoout_q <= '0;
         listo_q   <= 1'b0;
         error_q   <= 1'b0;
         ocupado_q <= 1'b0;
      end else begin
         actesc_q <= 1'b0;
         actlec_q <= 1'b0;
         listo_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cs && (readstrobe || writestrobe)) begin
                  // Read wins when both strobes are raised together
                  lectura_q <= readstrobe;
                  local_q   <= w_es_local;
                  valido_q  <= w_valido;
                  // A write aimed at a read-only register reports no index
                  dirmem_q  <= (w_valido && !(w_es_local && !readstrobe)) ?
                               w_dirmem : MAW'(DIRMEM_NONE);
                  datoreg_q <= dato;
                  error_q   <= 1'b0;
                  ocupado_q <= 1'b1;
                  state_q   <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (!valido_q || (local_q && !lectura_q)) begin
                  listo_q   <= 1'b1;
                  error_q   <= 1'b1;
                  datoout_q <= ERR_CODE[DW-1:0];
                  state_q   <= S_ERR;
               end else if (local_q) begin
                  state_q <= S_LOCAL;
               end else if (lectura_q) begin
                  actlec_q <= 1'b1;
                  cnt_q    <= TW'(TIMEOUT);
                  state_q  <= S_BUS_RD;
               end else begin
                  actesc_q <= 1'b1;
                  cnt_q    <= TW'(TIMEOUT);
                  state_q  <= S_BUS_WR;
               end
            end
            S_BUS_WR: begin
               // Ack is tested before expiry so a last-cycle ack still succeeds
               if (esclisto) begin
                  listo_q <= 1'b1;
                  state_q <= S_DONE;
               end else if (cnt_q == TW'(1)) begin
                  listo_q   <= 1'b1;
                  error_q   <= 1'b1;
                  datoout_q <= ERR_CODE[DW-1:0];
                  state_q   <= S_ERR;
               end else begin
                  cnt_q <= cnt_q - TW'(1);
               end
            end
            S_BUS_RD: begin
               if (memorialisto) begin
                  datoout_q <= datomem;
                  listo_q   <= 1'b1;
                  state_q   <= S_DONE;
               end else if (cnt_q == TW'(1)) begin
                  listo_q   <= 1'b1;
                  error_q   <= 1'b1;
                  datoout_q <= ERR_CODE[DW-1:0];
                  state_q   <= S_ERR;
               end else begin
                  cnt_q <= cnt_q - TW'(1);
               end
            end
            S_LOCAL: begin
               datoout_q <= datomem;
               listo_q   <= 1'b1;
               state_q   <= S_DONE;
            end
            S_DONE, S_ERR: begin
               state_q <= S_HOLD;
            end
            S_HOLD: begin
               // Only a cs release re-arms the bridge
               if (!cs) begin
                  ocupado_q <= 1'b0;
                  state_q   <= S_IDLE;
               end
            end
            default: begin
               ocupado_q <= 1'b0;
               state_q   <= S_IDLE;
            end
         endcase
      end
   end

   assign actesc  = actesc_q;
   assign actlec  = actlec_q;
   assign dirmem  = dirmem_q;
   assign datoreg = datoreg_q;
   assign datoout = datoout_q;
   assign listo   = listo_q;
   assign error   = error_q;
   assign ocupado = ocupado_q;

endmodule
`default_nettype wire

// File: tb/tb_control_puente_rtc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_puente_rtc
//  Description : Directed self-checking bench for the RTC bus bridge
//                (TIMEOUT set to 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_puente_rtc;

   logic       clk;
   logic       reset;
   logic       cs;
   logic       writestrobe;
   logic       readstrobe;
   logic [7:0] dir;
   logic [7:0] dato;
   logic [7:0] datomem;
   logic       esclisto;
   logic       memorialisto;
   logic       actesc;
   logic       actlec;
   logic [3:0] dirmem;
   logic [7:0] datoreg;
   logic [7:0] datoout;
   logic       listo;
   logic       error;
   logic       ocupado;

   int n_checks;
   int n_fail;

   // Per-transaction observations
   int n_esc, n_lec, n_lis;
   int c_esc, c_lec, c_lis;
   int dm_dec, dr_dec, err_dec;
   int err_l, out_l, busy_hold;
   int err_end, out_end, ocu_end;

   control_puente_rtc #(.TIMEOUT(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .cs           (cs),
      .writestrobe  (writestrobe),
      .readstrobe   (readstrobe),
      .dir          (dir),
      .dato         (dato),
      .datomem      (datomem),
      .esclisto     (esclisto),
      .memorialisto (memorialisto),
      .actesc       (actesc),
      .actlec       (actlec),
      .dirmem       (dirmem),
      .datoreg      (datoreg),
      .datoout      (datoout),
      .listo        (listo),
      .error        (error),
      .ocupado      (ocupado)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One transaction: strobes and cs stay high until 3 cycles after listo,
   // the engine ack (if ack_dly > 0) follows the request by ack_dly cycles.
   task automatic run_txn(input logic rd, input logic wr, input logic [7:0] d,
                          input logic [7:0] wd, input logic [7:0] mem,
                          input int ack_dly);
      int ack_at;
      logic ack_rd;
      n_esc = 0; n_lec = 0; n_lis = 0;
      c_esc = -1; c_lec = -1; c_lis = -1;
      ack_at = -1; ack_rd = 1'b0; busy_hold = -1;
      @(negedge clk);
      datomem = mem; dir = d; dato = wd;
      cs = 1'b1; readstrobe = rd; writestrobe = wr;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         esclisto = 1'b0; memorialisto = 1'b0;
         if (n == 1) begin
            dm_dec = int'(dirmem); dr_dec = int'(datoreg); err_dec = int'(error);
         end
         if (actesc) begin
            n_esc++; c_esc = n;
            if (ack_dly > 0) begin ack_at = n + ack_dly; ack_rd = 1'b0; end
         end
         if (actlec) begin
            n_lec++; c_lec = n;
            if (ack_dly > 0) begin ack_at = n + ack_dly; ack_rd = 1'b1; end
         end
         if (listo) begin
            n_lis++;
            if (c_lis < 0) begin
               c_lis = n; err_l = int'(error); out_l = int'(datoout);
            end
         end
         if (c_lis > 0 && n == c_lis + 2) busy_hold = int'(ocupado);
         if ((c_lis > 0 && n == c_lis + 3) || n == 25) begin
            cs = 1'b0; readstrobe = 1'b0; writestrobe = 1'b0;
         end
         if (n == ack_at) begin
            if (ack_rd) memorialisto = 1'b1;
            else        esclisto     = 1'b1;
         end
      end
      err_end = int'(error); out_end = int'(datoout); ocu_end = int'(ocupado);
   endtask

   initial begin
      logic seen;
      n_checks = 0; n_fail = 0;
      reset = 1'b0; cs = 1'b0; writestrobe = 1'b0; readstrobe = 1'b0;
      dir = '0; dato = '0; datomem = '0; esclisto = 1'b0; memorialisto = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_outputs", int'({actesc, actlec, dirmem, datoreg, datoout, listo, error, ocupado}), 0);
      reset = 1'b1;
      @(negedge clk);

      // Write to time register 0x23, ack 4 cycles after actesc
      run_txn(1'b0, 1'b1, 8'h23, 8'h59, 8'h00, 4);
      check("wr_dirmem", dm_dec, 3);
      check("wr_datoreg", dr_dec, 'h59);
      check("wr_actesc_cnt", n_esc, 1);
      check("wr_actlec_cnt", n_lec, 0);
      check("wr_listo_cnt", n_lis, 1);
      check("wr_error", err_l, 0);
      check("wr_hold_busy", busy_hold, 1);
      check("wr_idle_end", ocu_end, 0);

      // Read from date register 0x42, ack 2 cycles after actlec
      run_txn(1'b1, 1'b0, 8'h42, 8'h00, 8'h16, 2);
      check("rd_dirmem", dm_dec, 8);
      check("rd_actlec_cnt", n_lec, 1);
      check("rd_actesc_cnt", n_esc, 0);
      check("rd_datoout", out_l, 'h16);
      check("rd_listo_cnt", n_lis, 1);
      check("rd_error", err_l, 0);

      // Local register read 0x0B: no engine request, listo in cycle k+3
      run_txn(1'b1, 1'b0, 8'h0B, 8'h00, 8'hA5, 3);
      check("loc_dirmem", dm_dec, 11);
      check("loc_engine_req", n_esc + n_lec, 0);
      check("loc_datoout", out_l, 'hA5);
      check("loc_listo_cycle", c_lis, 3);
      check("loc_listo_cnt", n_lis, 1);

      // Unmapped read 0x50
      run_txn(1'b1, 1'b0, 8'h50, 8'h00, 8'h12, 2);
      check("unm_dirmem", dm_dec, 0);
      check("unm_engine_req", n_esc + n_lec, 0);
      check("unm_error", err_l, 1);
      check("unm_datoout", out_l, 'hFF);
      check("unm_error_persist", err_end, 1);
      check("unm_datoout_persist", out_end, 'hFF);

      // Write to read-only local register 0x0A; error from before must clear
      run_txn(1'b0, 1'b1, 8'h0A, 8'h33, 8'h12, 2);
      check("locwr_err_cleared", err_dec, 0);
      check("locwr_dirmem", dm_dec, 0);
      check("locwr_engine_req", n_esc + n_lec, 0);
      check("locwr_error", err_l, 1);
      check("locwr_datoout", out_l, 'hFF);

      // Write with no ack: timeout after 8 cycles, cs held keeps it in HOLD
      run_txn(1'b0, 1'b1, 8'h24, 8'h77, 8'h00, 0);
      check("to_dirmem", dm_dec, 4);
      check("to_actesc_cnt", n_esc, 1);
      check("to_latency", c_lis - c_esc, 8);
      check("to_error", err_l, 1);
      check("to_datoout", out_l, 'hFF);
      check("to_listo_cnt", n_lis, 1);
      check("to_hold_busy", busy_hold, 1);

      // Reset while waiting in BUS_RD
      @(negedge clk);
      dir = 8'h42; dato = 8'h5A; cs = 1'b1; readstrobe = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         if (actlec) seen = 1'b1;
      end
      check("rst_actlec_seen", int'(seen), 1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_outputs", int'({actesc, actlec, dirmem, datoreg, datoout, listo, error, ocupado}), 0);
      cs = 1'b0; readstrobe = 1'b0; reset = 1'b1;
      @(negedge clk);

      // Both strobes together: treated as a read
      run_txn(1'b1, 1'b1, 8'h42, 8'h66, 8'h3C, 2);
      check("both_actlec_cnt", n_lec, 1);
      check("both_actesc_cnt", n_esc, 0);
      check("both_datoout", out_l, 'h3C);
      check("both_error", err_l, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
